// File: rtl/spi_slave.sv
// Mode-0 SPI responder: 16-bit frames (RW, address, data) decoded onto a single-cycle register bus.
// Optional burst/auto-increment mode is enabled by defining SPI_SLAVE_AUTOINC_EN.
module spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int CMD_BITS   = 1 + ADDR_W;
  localparam int FRAME_BITS = CMD_BITS + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int SH_W       = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   cs_prev_q, cs_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SH_W-1:0]        shift_q, shift_d;
  logic [DATA_W-1:0]      tx_q, tx_d;
  logic                   rw_q, rw_d;
  logic                   re_p1_q, re_p1_d;
  logic                   re_p2_q, re_p2_d;
  logic                   inc_q, inc_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic [ADDR_W-1:0]      reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0]      reg_wdata_q, reg_wdata_d;
  logic                   reg_we_q, reg_we_d;
  logic                   reg_re_q, reg_re_d;
  logic                   done_q, done_d;

  logic            sck_s, cs_s, mosi_s;
  logic            sck_rise, sck_fall, cs_fall;
  logic [SH_W-1:0] shift_in;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;
  assign shift_in = {shift_q[SH_W-2:0], mosi_s};

  // Handshake: reg_we/reg_re are single-clk strobes qualified by reg_addr in the same clk;
  // reg_rdata is taken exactly two clk after the clk in which reg_re is high.
  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sck_prev_d  = sck_s;
    cs_prev_d   = cs_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    re_p1_d     = reg_re_q;
    re_p2_d     = re_p1_q;
    inc_d       = 1'b0;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    done_d      = 1'b0;

    if (re_p2_q) tx_d = reg_rdata;
    // Write bursts bump the address one clk late so reg_we sees the address just written.
    if (inc_q) reg_addr_d = reg_addr_q + ADDR_W'(1);

    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        if (cs_fall) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (cs_s) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else if (sck_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
            rw_d       = shift_in[CMD_BITS-1];
            reg_addr_d = shift_in[ADDR_W-1:0];
            reg_re_d   = shift_in[CMD_BITS-1];
            miso_oe_d  = shift_in[CMD_BITS-1];
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (cs_s) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end else if (sck_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            done_d = 1'b1;
            if (!rw_q) begin
              reg_we_d    = 1'b1;
              reg_wdata_d = shift_in[DATA_W-1:0];
            end
`ifdef SPI_SLAVE_AUTOINC_EN
            state_d = DATA;
            cnt_d   = CNT_W'(CMD_BITS);
            if (rw_q) begin
              reg_addr_d = reg_addr_q + ADDR_W'(1);
              reg_re_d   = 1'b1;
            end else begin
              inc_d = 1'b1;
            end
`else
            state_d = HOLD;
`endif
          end
        end else if (sck_fall && rw_q) begin
          miso_d = tx_q[DATA_W-1];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
      end
      HOLD: begin
        if (cs_s) begin
          state_d   = IDLE;
          miso_d    = 1'b0;
          miso_oe_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      re_p1_q     <= 1'b0;
      re_p2_q     <= 1'b0;
      inc_q       <= 1'b0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      cs_prev_q   <= cs_prev_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      re_p1_q     <= re_p1_d;
      re_p2_q     <= re_p2_d;
      inc_q       <= inc_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      done_q      <= done_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-byte frames plus abort, reset, extra-clock
// and (with SPI_SLAVE_AUTOINC_EN) burst sequences.
module tb_spi_slave;

  localparam int HALF = 8;
`ifdef SPI_SLAVE_AUTOINC_EN
  localparam int RE_PER_READ = 2;
`else
  localparam int RE_PER_READ = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, reg_we, reg_re, done;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;
  logic [1:0] dbg_state;

  spi_slave #(.SYNC_STAGES(2), .ADDR_W(7), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .done(done),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Monitor: counts strobes at negedge; only these blocks write these counters.
  int          cyc = 0;
  int          we_cnt = 0, re_cnt = 0, done_cnt = 0, oe_cnt = 0, we_cyc = 0;
  logic [14:0] act_q[$];
  logic [6:0]  re_addr_q[$];

  always @(posedge clk) cyc = cyc + 1;

  always @(negedge clk) begin
    if (reg_we) begin
      we_cnt = we_cnt + 1;
      we_cyc = cyc;
      act_q.push_back({reg_addr, reg_wdata});
    end
    if (reg_re) begin
      re_cnt = re_cnt + 1;
      re_addr_q.push_back(reg_addr);
    end
    if (done) done_cnt = done_cnt + 1;
    if (miso_oe) oe_cnt = oe_cnt + 1;
  end

  // Scoreboard
  logic [14:0] exp_q[$];
  int n_run = 0, n_fail = 0;
  int act_idx = 0, re_idx = 0;
  int b_we, b_re, b_done, b_oe;
  int rise16_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run = n_run + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_we = we_cnt; b_re = re_cnt; b_done = done_cnt; b_oe = oe_cnt;
  endtask

  task automatic check_writes(input string name);
    logic [14:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (act_idx < act_q.size()) begin
        check(name, 32'(act_q[act_idx]), 32'(e));
        act_idx = act_idx + 1;
      end else begin
        check({name, "_missing"}, 32'(act_q.size()), 32'(act_idx + 1));
      end
    end
    act_idx = act_q.size();
  endtask

  task automatic spi_pulses(input logic [31:0] bits, input int nbits, input int npulses,
                            output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < npulses; i++) begin
      mosi = (i < nbits) ? bits[5'(nbits - 1 - i)] : 1'b0;
      repeat (HALF) @(negedge clk);
      if (i >= 8 && i < 16) rx = {rx[6:0], miso};
      sck = 1'b1;
      if (i == 15) rise16_cyc = cyc;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic spi_frame(input logic [31:0] bits, input int nbits, input int npulses,
                           output logic [7:0] rx);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_pulses(bits, nbits, npulses, rx);
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
    logic [7:0] rdata;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] rx;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{rw: 1'b0, addr: 7'h72, data: 8'hA3, rdata: 8'h00};
    vecs[1] = '{rw: 1'b1, addr: 7'h05, data: 8'h00, rdata: 8'h5C};
    vecs[2] = '{rw: 1'b0, addr: 7'h00, data: 8'hFF, rdata: 8'h00};
    vecs[3] = '{rw: 1'b0, addr: 7'h7F, data: 8'h01, rdata: 8'h00};
    vecs[4] = '{rw: 1'b1, addr: 7'h7F, data: 8'h00, rdata: 8'hA5};
    vecs[5] = '{rw: 1'b1, addr: 7'h40, data: 8'h00, rdata: 8'h81};

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_miso", 32'(miso), 0);
    check("rst_miso_oe", 32'(miso_oe), 0);
    check("rst_reg_addr", 32'(reg_addr), 0);
    check("rst_reg_wdata", 32'(reg_wdata), 0);
    check("rst_strobes", 32'({reg_we, reg_re, done}), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Table-driven single-byte frames
    for (int v = 0; v < 6; v++) begin
      reg_rdata = vecs[v].rdata;
      snap();
      if (!vecs[v].rw) exp_q.push_back({vecs[v].addr, vecs[v].data});
      spi_frame({16'h0, vecs[v].rw, vecs[v].addr, vecs[v].data}, 16, 16, rx);
      check($sformatf("v%0d_done", v), 32'(done_cnt - b_done), 1);
      check($sformatf("v%0d_state_after_cs", v), 32'(dbg_state), 0);
      check($sformatf("v%0d_miso_oe_after_cs", v), 32'({miso_oe, miso}), 0);
      if (vecs[v].rw) begin
        check($sformatf("v%0d_re_count", v), 32'(re_cnt - b_re), RE_PER_READ);
        check($sformatf("v%0d_we_count", v), 32'(we_cnt - b_we), 0);
        if (re_idx < re_addr_q.size())
          check($sformatf("v%0d_re_addr", v), 32'(re_addr_q[re_idx]), 32'(vecs[v].addr));
        else
          check($sformatf("v%0d_re_addr_missing", v), 32'(re_addr_q.size()), 32'(re_idx + 1));
        re_idx = re_addr_q.size();
        check($sformatf("v%0d_miso_byte", v), 32'(rx), 32'(vecs[v].rdata));
        check($sformatf("v%0d_miso_oe_seen", v), 32'(oe_cnt - b_oe > 0), 1);
      end else begin
        check($sformatf("v%0d_we_count", v), 32'(we_cnt - b_we), 1);
        check($sformatf("v%0d_re_count", v), 32'(re_cnt - b_re), 0);
        check($sformatf("v%0d_miso_oe_cycles", v), 32'(oe_cnt - b_oe), 0);
        check_writes($sformatf("v%0d_write", v));
        if (v == 0) check("we_latency", 32'(we_cyc - rise16_cyc), 3);
      end
    end

    // Abort after 11 bits of a write to 7'h10, then a good write to 7'h11
    snap();
    spi_frame({16'h0, 1'b0, 7'h10, 8'hEE}, 16, 11, rx);
    check("abort_we", 32'(we_cnt - b_we), 0);
    check("abort_done", 32'(done_cnt - b_done), 0);
    check("abort_state", 32'(dbg_state), 0);
    snap();
    exp_q.push_back({7'h11, 8'h3C});
    spi_frame({16'h0, 1'b0, 7'h11, 8'h3C}, 16, 16, rx);
    check("post_abort_we", 32'(we_cnt - b_we), 1);
    check_writes("post_abort_write");

    // Asynchronous reset mid-DATA of a read
    reg_rdata = 8'h96;
    cs = 1'b0;
    repeat (4) @(negedge clk);
    spi_pulses({16'h0, 1'b1, 7'h2A, 8'h00}, 16, 12, rx);
    repeat (2) @(negedge clk);
    check("pre_reset_miso_oe", 32'(miso_oe), 1);
    check("pre_reset_addr", 32'(reg_addr), 32'h2A);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_miso_oe", 32'(miso_oe), 0);
    check("async_rst_outputs", 32'({miso, reg_we, reg_re, done}), 0);
    check("async_rst_addr", 32'(reg_addr), 0);
    check("async_rst_state", 32'(dbg_state), 0);
    cs = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    act_idx = act_q.size();
    re_idx  = re_addr_q.size();
    snap();
    exp_q.push_back({7'h33, 8'h5A});
    spi_frame({16'h0, 1'b0, 7'h33, 8'h5A}, 16, 16, rx);
    check("post_reset_we", 32'(we_cnt - b_we), 1);
    check("post_reset_done", 32'(done_cnt - b_done), 1);
    check_writes("post_reset_write");

`ifdef SPI_SLAVE_AUTOINC_EN
    // Burst write across the address wrap
    snap();
    exp_q.push_back({7'h7F, 8'h11});
    exp_q.push_back({7'h00, 8'h22});
    spi_frame({8'h0, 1'b0, 7'h7F, 8'h11, 8'h22}, 24, 24, rx);
    check("burst_we", 32'(we_cnt - b_we), 2);
    check("burst_done", 32'(done_cnt - b_done), 2);
    check_writes("burst_write");
`else
    // Extra sck pulses are absorbed after the byte completes
    snap();
    exp_q.push_back({7'h72, 8'hA3});
    spi_frame({16'h0, 1'b0, 7'h72, 8'hA3}, 16, 20, rx);
    check("extra_clk_we", 32'(we_cnt - b_we), 1);
    check("extra_clk_done", 32'(done_cnt - b_done), 1);
    check_writes("extra_clk_write");
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder (mode 0, CPOL=0/CPHA=0, MSB first) for the team's SPI master.
- Decodes 16-bit frames: R/W bit, then 7-bit address, then 8-bit data.
- Presents decoded accesses on a simple single-cycle register bus toward local registers.
- Oversamples sck/cs/mosi in the clk domain; no logic is clocked by sck.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on sck, cs and mosi (minimum 2).
- ADDR_W, 7, address field width.
- DATA_W, 8, data field width.

Ports:
- clk  input  1  system clock; requires f_clk >= 8 x f_sck.
- rst_n  input  1  asynchronous reset, active-low.
- sck  input  1  SPI clock from master.
- cs  input  1  chip select, active-low.
- mosi  input  1  serial data from master.
- miso  output  1  serial data to master.
- miso_oe  output  1  miso drive enable; high only during the read data phase.
- reg_addr  output  ADDR_W  latched access address.
- reg_wdata  output  DATA_W  write data.
- reg_we  output  1  write strobe, 1 clk.
- reg_re  output  1  read request strobe, 1 clk.
- reg_rdata  input  DATA_W  read data; sampled exactly 2 clk after reg_re.
- done  output  1  frame-complete pulse, 1 clk.

Behaviour:
- Reset values: miso=0, miso_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, done=0, state=IDLE.
- Reset is honoured at any point, including mid-frame.
- Synchronizers: sck/cs/mosi pass through SYNC_STAGES flops.
  - rise/fall = edge detect on synchronized sck.
  - mosi is sampled together with the synchronized sck rise.
- Bit ordering:
  - Bit 0 = RW: 0 = write, 1 = read.
  - Bits 1..7 = address, MSB first.
  - Bits 8..15 = data, MSB first.
- States: IDLE, CMD, DATA, HOLD.
  - IDLE: cs sync falling -> CMD, bit counter = 0.
  - CMD: shift mosi on each sck rise. On the 8th rise:
    - latch rw and reg_addr.
    - If rw=1: pulse reg_re the following clk; capture reg_rdata 2 clk after reg_re into the tx shift register.
    - Move to DATA.
  - DATA, write: shift mosi on each sck rise. On the 8th rise:
    - reg_wdata <= shifted byte.
    - reg_we=1 and done=1 for 1 clk.
    - Move to HOLD.
  - DATA, read:
    - miso_oe=1 from entry into DATA.
    - miso = tx MSB, loaded on the first sck fall after the 8th command rise.
    - Tx shifts left on each subsequent sck fall.
    - On the 8th data rise: done=1 for 1 clk, then HOLD.
  - HOLD: ignore sck; cs sync high -> IDLE, miso_oe=0, miso=0.
- cs high in CMD or DATA (abort):
  - return to IDLE, no reg_we, no done.
  - miso_oe=0 next clk.
  - A reg_re already issued is not retracted.
- cs high and sck edge detected in the same clk: cs wins; the edge is ignored.
- sck edges while in IDLE are ignored.
- Bit counter is 4 bits; it never wraps inside a frame because HOLD absorbs extra clocks.
- Latency:
  - reg_we asserts SYNC_STAGES+1 clk after the 16th physical sck rise.
  - Read data must be in tx before the 8th sck fall; guaranteed by the f_clk >= 8 x f_sck rule.

Optional Feature:
- Macro: SPI_SLAVE_AUTOINC_EN.
- Defined, burst mode:
  - After a data byte completes, if cs remains low, return to DATA (not HOLD) with reg_addr+1.
  - Address wraps 7'h7F -> 7'h00.
  - Each byte gets its own reg_we (write) or reg_re (read).
  - Reads: the next byte is requested on the 8th data rise of the current byte.
  - done pulses per byte.
- Undefined: one byte per frame; extra sck edges are ignored in HOLD until cs high.

Test Plan:
- Write: cs low, shift 0,1110010,10100011 -> one reg_we with reg_addr=7'h72, reg_wdata=8'hA3; one done pulse; miso_oe stays 0.
- Read: frame 1,0000101, reg_rdata=8'h5C -> reg_re once with reg_addr=7'h05; miso bits 0,1,0,1,1,1,0,0 on successive data rises; done pulses; miso_oe drops after cs high.
- Abort: cs high after 11 bits of a write to 7'h10 -> no reg_we, no done, state IDLE; a following full write to 7'h11 data 8'h3C succeeds.
- Async reset mid-DATA: rst_n low after 12 bits -> all outputs 0 immediately; the next frame decodes correctly.
- Extra clocks: 20 sck pulses in one write frame -> exactly one reg_we (8'hA3 to 7'h72) with macro undefined.
- With SPI_SLAVE_AUTOINC_EN: write 7'h7F with bytes 8'h11, 8'h22 in one cs window -> reg_we to 7'h7F = 8'h11, then 7'h00 = 8'h22; two done pulses.
